// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared types and constants for the ALU operand sequencer.
//   alu_seq_state_t : sequencer FSM states
//   N_OPS           : number of ALU operand lanes (a, b, c, d, e)
//   IDX_*           : lane index of each operand
//   LAST_IDX_*      : index of the final operand beat for each mode
//   next_idx()      : beat-index advance rule for a given mode
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_HOLD   = 2'd3
  } alu_seq_state_t;

  localparam int N_OPS = 5;
  localparam int IDX_W = 3;

  localparam logic [IDX_W-1:0] IDX_A = 3'd0;
  localparam logic [IDX_W-1:0] IDX_B = 3'd1;
  localparam logic [IDX_W-1:0] IDX_C = 3'd2;
  localparam logic [IDX_W-1:0] IDX_D = 3'd3;
  localparam logic [IDX_W-1:0] IDX_E = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX_MAC = IDX_E;
  localparam logic [IDX_W-1:0] LAST_IDX_ADD = IDX_C;

  // MAC walks every lane in order; ADD only needs a then c, so it jumps
  // straight from lane a to lane c.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                 input logic            add_mode);
    if (add_mode) begin
      next_idx = IDX_C;
    end else begin
      next_idx = idx + 3'd1;
    end
  endfunction

  function automatic logic [IDX_W-1:0] last_idx(input logic add_mode);
    last_idx = add_mode ? LAST_IDX_ADD : LAST_IDX_MAC;
  endfunction

endpackage : alu_seq_pkg

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Operand sequencer for the fixed-point ALU (a*b + c*d + e, or a + c).
// Takes a command beat, streams operand bytes into the ALU input registers
// one per handshake, captures the ALU result and offers it on a valid/ready
// output channel.
//
// Ports
//   clk, n_reset            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     : command channel, cmd_add selects ADD (1) / MAC (0)
//   in_valid/in_ready       : operand channel, in_data is the operand byte
//   alu_ops                 : to ALU ops, every lane carries in_data
//   alu_reg_en              : to ALU reg_en, one-hot on an accepted beat
//   alu_f_add               : to ALU f_add, mode latched at the command
//   alu_result              : from ALU result
//   res_valid/res_ready     : result channel, res_data is the captured result
// ---------------------------------------------------------------------------
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              n_reset,
  // command channel
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_add,
  // operand channel
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BUS_WIDTH-1:0]              in_data,
  // ALU side
  output logic [N_OPS-1:0][BUS_WIDTH-1:0]   alu_ops,
  output logic [N_OPS-1:0]                  alu_reg_en,
  output logic                              alu_f_add,
  input  logic [BUS_WIDTH-1:0]              alu_result,
  // result channel
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [BUS_WIDTH-1:0]              res_data
);

  alu_seq_state_t          state_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic                    f_add_reg;
  logic [BUS_WIDTH-1:0]    res_data_reg;

  logic                    in_fire;

  assign in_fire = in_valid && (state_reg == ST_LOAD);

  // -------------------------------------------------------------------------
  // Sequencer FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= IDX_A;
      f_add_reg    <= 1'b0;
      res_data_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            f_add_reg <= cmd_add;
            idx_reg   <= IDX_A;
            state_reg <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (in_valid) begin
            if (idx_reg == last_idx(f_add_reg)) begin
              idx_reg   <= IDX_A;
              state_reg <= ST_SETTLE;
            end else begin
              idx_reg <= next_idx(idx_reg, f_add_reg);
            end
          end
        end

        // The final operand was written into the ALU on the previous edge,
        // so the ALU output now reflects the complete operand set.
        ST_SETTLE: begin
          res_data_reg <= alu_result;
          state_reg    <= ST_HOLD;
        end

        ST_HOLD: begin
          if (res_ready) begin
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign cmd_ready = (state_reg == ST_IDLE);
  assign in_ready  = (state_reg == ST_LOAD);
  assign res_valid = (state_reg == ST_HOLD);
  assign res_data  = res_data_reg;
  assign alu_f_add = f_add_reg;

  // The enable must land in the same cycle as the accepted beat, because the
  // ALU registers sample ops on that same edge.
  generate
    for (genvar gi = 0; gi < N_OPS; gi++) begin : g_lane
      assign alu_ops[gi]    = in_data;
      assign alu_reg_en[gi] = in_fire && (idx_reg == IDX_W'(gi));
    end
  endgenerate

endmodule : alu_seq
